// File: rtl/cu_pkg.sv
// +----------------------------------------------------------------------+
// | cu_pkg : shared opcodes, FSM states and select encodings for the CU. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package cu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_HALT   = 7'b0000000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  localparam logic [1:0] OP1_PC   = 2'b00;
  localparam logic [1:0] OP1_RS1  = 2'b01;
  localparam logic [1:0] OP1_ZERO = 2'b10;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef enum logic [2:0] {
    K_ALU    = 3'd0,
    K_LOAD   = 3'd1,
    K_STORE  = 3'd2,
    K_BRANCH = 3'd3,
    K_JUMP   = 3'd4
  } kind_t;

  typedef struct packed {
    kind_t      kind;
    logic [2:0] alu_func3;
    logic       alu_subsra;
    logic [2:0] mem_func3;
    logic [1:0] op1_sel;
    logic       op2_sel;
    logic [1:0] wb_sel;
  } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/multicycle_cu_if.sv
// +----------------------------------------------------------------------+
// | multicycle_cu_if : instruction and data memory handshake bundle.     |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

interface multicycle_cu_if #(
  parameter int XLEN = 32
) ();
  logic            imem_req;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic            dmem_ack;

  modport master (
    output imem_req,
    input  imem_ack,
    input  imem_rdata,
    output dmem_req,
    output dmem_we,
    input  dmem_ack
  );

  modport slave (
    input  imem_req,
    output imem_ack,
    output imem_rdata,
    input  dmem_req,
    input  dmem_we,
    output dmem_ack
  );
endinterface

`default_nettype wire

// File: rtl/cu_decoder.sv
// +----------------------------------------------------------------------+
// | cu_decoder : combinational IR to control-bundle decode, halt/illegal.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module cu_decoder
  import cu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic [XLEN-1:0]   ir,
  output ctrl_t             ctrl,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic              halt,
  output logic              illegal
);

  logic [6:0] opcode;
  logic [2:0] func3;
  logic       use_rs1;
  logic       use_rs2;
  logic       use_rd;
  logic       unused_ir;

  assign opcode    = ir[6:0];
  assign func3     = ir[14:12];
  assign unused_ir = ^{ir[XLEN-1:31], ir[29:25]};

  always_comb begin
    ctrl         = '0;
    ctrl.op1_sel = OP1_RS1;
    ctrl.op2_sel = 1'b1;
    ctrl.wb_sel  = WB_ALU;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    use_rd       = 1'b0;
    halt         = 1'b0;
    illegal      = 1'b0;
    case (opcode)
      OPC_OP: begin
        ctrl.alu_func3  = func3;
        ctrl.alu_subsra = ir[30];
        ctrl.op2_sel    = 1'b0;
        {use_rs1, use_rs2, use_rd} = 3'b111;
      end
      OPC_OPIMM: begin
        // ir[30] is immediate data except for the shift-right pair
        ctrl.alu_func3  = func3;
        ctrl.alu_subsra = (func3 == 3'b101) && ir[30];
        {use_rs1, use_rd} = 2'b11;
      end
      OPC_LOAD: begin
        ctrl.kind      = K_LOAD;
        ctrl.mem_func3 = func3;
        ctrl.wb_sel    = WB_MEM;
        {use_rs1, use_rd} = 2'b11;
      end
      OPC_STORE: begin
        ctrl.kind      = K_STORE;
        ctrl.mem_func3 = func3;
        {use_rs1, use_rs2} = 2'b11;
      end
      OPC_BRANCH: begin
        ctrl.kind    = K_BRANCH;
        ctrl.op1_sel = OP1_PC;
        {use_rs1, use_rs2} = 2'b11;
      end
      OPC_JALR: begin
        ctrl.kind   = K_JUMP;
        ctrl.wb_sel = WB_PC4;
        {use_rs1, use_rd} = 2'b11;
      end
      OPC_JAL: begin
        ctrl.kind    = K_JUMP;
        ctrl.op1_sel = OP1_PC;
        ctrl.wb_sel  = WB_PC4;
        use_rd       = 1'b1;
      end
      OPC_LUI: begin
        ctrl.op1_sel = OP1_ZERO;
        use_rd       = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.op1_sel = OP1_PC;
        use_rd       = 1'b1;
      end
      OPC_HALT: begin
        halt = 1'b1;
      end
      default: begin
        halt    = 1'b1;
        illegal = 1'b1;
      end
    endcase
    rs1 = use_rs1 ? REG_AW'(ir[19:15]) : '0;
    rs2 = use_rs2 ? REG_AW'(ir[24:20]) : '0;
    rd  = use_rd  ? REG_AW'(ir[11:7])  : '0;
  end

endmodule

`default_nettype wire

// File: rtl/multicycle_cu.sv
// +----------------------------------------------------------------------+
// | multicycle_cu : FETCH/DECODE/EXEC/MEM/WB/HALT control FSM for RV32I. |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module multicycle_cu
  import cu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  multicycle_cu_if.master   bus,
  input  logic              branch_taken,
  output logic [XLEN-1:0]   ir,
  output logic [REG_AW-1:0] rs1,
  output logic [REG_AW-1:0] rs2,
  output logic [REG_AW-1:0] rd,
  output logic [2:0]        alu_func3,
  output logic              alu_subsra,
  output logic [2:0]        mem_func3,
  output logic [1:0]        op1_sel,
  output logic              op2_sel,
  output logic [1:0]        wb_sel,
  output logic              rf_we,
  output logic              pc_we,
  output logic              pc_sel,
  output logic              halted,
  output logic              illegal
);

  state_t            state;
  logic              run;
  ctrl_t             ctrl_q;
  ctrl_t             dec_ctrl;
  logic [REG_AW-1:0] dec_rs1;
  logic [REG_AW-1:0] dec_rs2;
  logic [REG_AW-1:0] dec_rd;
  logic              dec_halt;
  logic              dec_illegal;
  logic              w_branch_fire;
  logic              w_store_done;

  cu_decoder #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_decoder (
    .ir      (ir),
    .ctrl    (dec_ctrl),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .rd      (dec_rd),
    .halt    (dec_halt),
    .illegal (dec_illegal)
  );

  assign alu_func3  = ctrl_q.alu_func3;
  assign alu_subsra = ctrl_q.alu_subsra;
  assign mem_func3  = ctrl_q.mem_func3;
  assign op1_sel    = ctrl_q.op1_sel;
  assign op2_sel    = ctrl_q.op2_sel;
  assign wb_sel     = ctrl_q.wb_sel;

  // run keeps the fetch request low until the first clock after reset
  assign bus.imem_req = run && (state == FETCH);
  assign bus.dmem_req = (state == MEM);
  assign bus.dmem_we  = (state == MEM) && (ctrl_q.kind == K_STORE);

  assign w_branch_fire = (state == EXEC) && (ctrl_q.kind == K_BRANCH);
  assign w_store_done  = (state == MEM) && (ctrl_q.kind == K_STORE) && bus.dmem_ack;

  assign pc_we  = w_branch_fire || w_store_done || (state == WB);
  assign pc_sel = (w_branch_fire && branch_taken) ||
                  ((state == WB) && (ctrl_q.kind == K_JUMP));
  assign rf_we  = (state == WB) && (rd != '0);
  assign halted = (state == HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      run     <= 1'b0;
      ir      <= '0;
      ctrl_q  <= '0;
      rs1     <= '0;
      rs2     <= '0;
      rd      <= '0;
      illegal <= 1'b0;
    end else begin
      run <= 1'b1;
      case (state)
        FETCH: begin
          if (run && bus.imem_ack) begin
            ir    <= bus.imem_rdata;
            state <= DECODE;
          end
        end
        DECODE: begin
          ctrl_q <= dec_ctrl;
          rs1    <= dec_rs1;
          rs2    <= dec_rs2;
          rd     <= dec_rd;
          if (dec_halt) begin
            illegal <= dec_illegal;
            state   <= HALT;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          case (ctrl_q.kind)
            K_LOAD, K_STORE: state <= MEM;
            K_BRANCH:        state <= FETCH;
            default:         state <= WB;
          endcase
        end
        MEM: begin
          if (bus.dmem_ack) begin
            state <= (ctrl_q.kind == K_STORE) ? FETCH : WB;
          end
        end
        WB:      state <= FETCH;
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multicycle_cu.sv
// +----------------------------------------------------------------------+
// | tb_multicycle_cu : randomized scoreboard bench for multicycle_cu.    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_multicycle_cu;

  localparam logic [6:0] T_OP = 7'b0110011, T_OPIMM = 7'b0010011, T_LOAD = 7'b0000011,
                         T_STORE = 7'b0100011, T_BRANCH = 7'b1100011, T_JALR = 7'b1100111,
                         T_JAL = 7'b1101111, T_LUI = 7'b0110111, T_AUIPC = 7'b0010111;

  typedef struct {
    int         lat;
    int         dreq;
    bit         dwe;
    bit         pc_sel;
    bit         rf_we;
    bit         halt;
    bit         illegal;
    logic [4:0] rs1, rs2, rd;
    logic [2:0] af3, mf3;
    bit         sub;
    logic [1:0] op1, wb;
    bit         op2;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch_taken;
  logic [31:0] ir;
  logic [4:0]  rs1, rs2, rd;
  logic [2:0]  alu_func3, mem_func3;
  logic        alu_subsra, op2_sel, rf_we, pc_we, pc_sel, halted, illegal;
  logic [1:0]  op1_sel, wb_sel;

  multicycle_cu_if #(.XLEN(32)) bus ();

  multicycle_cu #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .bus(bus), .branch_taken(branch_taken),
    .ir(ir), .rs1(rs1), .rs2(rs2), .rd(rd),
    .alu_func3(alu_func3), .alu_subsra(alu_subsra), .mem_func3(mem_func3),
    .op1_sel(op1_sel), .op2_sel(op2_sel), .wb_sel(wb_sel),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  exp_t        q[$];
  logic [31:0] cur_instr = 32'h0;
  int          imem_wait = 0;
  int          dmem_wait = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: classify the instruction, then derive selects and cycle counts
  function automatic exp_t model(input logic [31:0] ins, input bit bt, input int iw, input int dw);
    exp_t e;
    bit r1 = 0, r2 = 0, wr = 0, ld = 0, st = 0, br = 0, jmp = 0;
    logic [2:0] f3 = ins[14:12];
    e = '{default: 0};
    e.op1 = 2'b01; e.op2 = 1'b1; e.wb = 2'b01;
    case (ins[6:0])
      T_OP:     begin r1 = 1; r2 = 1; wr = 1; e.af3 = f3; e.sub = ins[30]; e.op2 = 1'b0; end
      T_OPIMM:  begin r1 = 1; wr = 1; e.af3 = f3; e.sub = (f3 == 3'd5) ? ins[30] : 1'b0; end
      T_LOAD:   begin r1 = 1; wr = 1; ld = 1; e.mf3 = f3; e.wb = 2'b00; end
      T_STORE:  begin r1 = 1; r2 = 1; st = 1; e.mf3 = f3; end
      T_BRANCH: begin r1 = 1; r2 = 1; br = 1; e.op1 = 2'b00; end
      T_JALR:   begin r1 = 1; wr = 1; jmp = 1; e.wb = 2'b10; end
      T_JAL:    begin wr = 1; jmp = 1; e.op1 = 2'b00; e.wb = 2'b10; end
      T_LUI:    begin wr = 1; e.op1 = 2'b10; end
      T_AUIPC:  begin wr = 1; e.op1 = 2'b00; end
      7'b0000000: e.halt = 1;
      default:  begin e.halt = 1; e.illegal = 1; end
    endcase
    e.rs1 = r1 ? ins[19:15] : 5'd0;
    e.rs2 = r2 ? ins[24:20] : 5'd0;
    e.rd  = wr ? ins[11:7]  : 5'd0;
    e.rf_we  = wr && (ins[11:7] != 5'd0);
    e.pc_sel = br ? bt : jmp;
    e.dreq   = (ld || st) ? 1 + dw : 0;
    e.dwe    = st;
    if (e.halt)   e.lat = (1 + iw) + 2;
    else if (br)  e.lat = (1 + iw) + 2;
    else if (st)  e.lat = (1 + iw) + 2 + (1 + dw);
    else if (ld)  e.lat = (1 + iw) + 3 + (1 + dw);
    else          e.lat = (1 + iw) + 3;
    return e;
  endfunction

  // Memory responders: wait states when requested, random ack noise otherwise
  initial begin : responder
    int icnt = 0, dcnt = 0;
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        icnt = 0; dcnt = 0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
      end else begin
        if (bus.imem_req) begin
          if (icnt >= imem_wait) begin bus.imem_ack = 1'b1; bus.imem_rdata = cur_instr; end
          else begin bus.imem_ack = 1'b0; bus.imem_rdata = $urandom; icnt++; end
        end else begin
          icnt = 0; bus.imem_ack = 1'($urandom_range(0, 1)); bus.imem_rdata = $urandom;
        end
        if (bus.dmem_req) begin
          if (dcnt >= dmem_wait) bus.dmem_ack = 1'b1;
          else begin bus.dmem_ack = 1'b0; dcnt++; end
        end else begin
          dcnt = 0; bus.dmem_ack = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  initial begin : monitor
    bit   busy = 0;
    int   cyc = 0, rf_cnt = 0, dreq_cnt = 0, dwe_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin busy = 0; continue; end
      if (!busy && bus.imem_req) begin
        busy = 1; cyc = 0; rf_cnt = 0; dreq_cnt = 0; dwe_cnt = 0;
      end
      if (busy) begin
        cyc++;
        if (rf_we) rf_cnt++;
        if (bus.dmem_req) dreq_cnt++;
        if (bus.dmem_we) dwe_cnt++;
      end
      if (pc_we || (busy && halted)) begin
        if (!busy || q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: pc_we=%0b halted=%0b with nothing outstanding (t=%0t)",
                   pc_we, halted, $time);
        end else begin
          e = q.pop_front();
          chk("halted", halted, e.halt);
          chk("illegal", illegal, e.illegal);
          chk("latency", cyc, e.lat);
          if (!e.halt) begin
            chk("pc_sel", pc_sel, e.pc_sel);
            chk("rf_we_at_pc_we", rf_we, e.rf_we);
            chk("rf_we_pulses", rf_cnt, e.rf_we ? 1 : 0);
            chk("dmem_req_cycles", dreq_cnt, e.dreq);
            chk("dmem_we_cycles", dwe_cnt, e.dwe ? e.dreq : 0);
            chk("rs1", rs1, e.rs1);
            chk("rs2", rs2, e.rs2);
            chk("rd", rd, e.rd);
            chk("alu_func3", alu_func3, e.af3);
            chk("alu_subsra", alu_subsra, e.sub);
            chk("mem_func3", mem_func3, e.mf3);
            chk("op1_sel", op1_sel, e.op1);
            chk("op2_sel", op2_sel, e.op2);
            chk("wb_sel", wb_sel, e.wb);
          end
          busy = 0;
        end
      end
    end
  end

  task automatic run_instr(input logic [31:0] ins, input bit bt, input int iw, input int dw);
    int n = 0;
    cur_instr = ins; imem_wait = iw; dmem_wait = dw; branch_taken = bt;
    q.push_back(model(ins, bt, iw, dw));
    while (q.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout: instr 0x%08h not retired within %0d cycles", ins, n);
      q.delete();
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r = $urandom;
    case ($urandom_range(0, 8))
      0: r[6:0] = T_OP;     1: r[6:0] = T_OPIMM; 2: r[6:0] = T_LOAD;
      3: r[6:0] = T_STORE;  4: r[6:0] = T_BRANCH; 5: r[6:0] = T_JALR;
      6: r[6:0] = T_JAL;    7: r[6:0] = T_LUI;   default: r[6:0] = T_AUIPC;
    endcase
    return r;
  endfunction

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    bit seen;
    int n;
    reset = 1'b1; branch_taken = 1'b0;
    #3;
    chk("reset_ir", ir, 0);
    chk("reset_outputs", {rs1, rs2, rd, alu_func3, alu_subsra, mem_func3, op1_sel, op2_sel,
                          wb_sel, rf_we, pc_we, pc_sel, halted, illegal,
                          bus.imem_req, bus.dmem_req, bus.dmem_we}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    run_instr(32'h002081B3, 1'b0, 0, 0);   // add x3,x1,x2
    run_instr(32'h0080A283, 1'b0, 0, 3);   // lw x5,8(x1)
    run_instr(32'h0020A223, 1'b0, 0, 0);   // sw x2,4(x1)
    run_instr(32'h00208463, 1'b1, 0, 0);   // beq taken
    run_instr(32'h00208463, 1'b0, 0, 0);   // beq not taken
    run_instr(32'h4030D213, 1'b0, 0, 0);   // srai x4,x1,3
    run_instr(32'h4030D213, 1'b0, 2, 0);   // same with fetch wait states

    for (int i = 0; i < 60; i++)
      run_instr(rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 3));

    run_instr(32'h0000007F, 1'b0, 1, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.imem_req || pc_we || rf_we || bus.dmem_req) seen = 1;
    end
    chk("halt_quiet", seen, 0);
    chk("halt_hold", {halted, illegal}, 2'b11);

    @(posedge clk); #2; reset = 1'b1; #1;
    chk("reset_from_halt", {halted, illegal}, 2'b00);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Reset while a load is stalled in MEM
    cur_instr = 32'h0080A283; imem_wait = 0; dmem_wait = 20;
    n = 0;
    while (!bus.dmem_req && n < 50) begin @(negedge clk); n++; end
    chk("reached_mem", bus.dmem_req, 1);
    @(posedge clk); #2; reset = 1'b1; #1;
    chk("reset_drops_dmem_req", {bus.dmem_req, bus.dmem_we, pc_we, rf_we}, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_instr(32'h002081B3, 1'b0, 0, 0);
    run_instr(32'h0080A283, 1'b0, 1, 1);

    run_instr(32'h00000000, 1'b0, 0, 0);
    repeat (3) @(negedge clk);
    chk("zero_halt_hold", {halted, illegal, bus.imem_req}, 3'b100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multicycle_cu.md
# multicycle_cu

Parametrised multicycle control unit for the RV32I core. It replaces the single-cycle decode-every-clock controller with an explicit FSM: FETCH, DECODE, EXEC, MEM, WB, HALT. It has ready/acknowledge handshakes to instruction and data memory, so wait-state memories are tolerated. It drives the same datapath mux, ALU, register-file and data-memory controls, and adds AUIPC, a zero operand for LUI, a correct SRAI/SRLI distinction and illegal-opcode trapping.

## Interface
- XLEN, 32, instruction/IR width.
- REG_AW, 5, register index width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock, async active-high reset.
- imem_req  out  1  fetch request.
- imem_ack  in  1  fetch data valid this cycle; may be combinational from imem_req.
- imem_rdata  in  XLEN  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  store when 1, load when 0.
- dmem_ack  in  1  data access complete.
- branch_taken  in  1  branch unit result for the current IR.
- ir  out  XLEN  latched instruction, which also feeds the immediate unit.
- rs1, rs2, rd  out  REG_AW each  register indices.
- alu_func3  out  3  ALU operation.
- alu_subsra  out  1  SUB/SRA select.
- mem_func3  out  3  data-memory size/sign control.
- op1_sel  out  2  00 PC, 01 rs1, 10 zero.
- op2_sel  out  1  0 rs2, 1 immediate.
- wb_sel  out  2  00 data memory, 01 ALU, 10 PC+4.
- rf_we  out  1  register write strobe.
- pc_we  out  1  PC update strobe.
- pc_sel  out  1  0 PC+4, 1 ALU result.
- halted  out  1  FSM in HALT.
- illegal  out  1  HALT entered via an unknown opcode.

## Operation
- FETCH: imem_req=1. When imem_ack=1, latch imem_rdata into ir and go to DECODE. Otherwise stay in FETCH.
- DECODE: register all control fields from ir.
  - opcode 0000000 goes to HALT with illegal=0.
  - Any opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111} goes to HALT with illegal=1.
  - Every other opcode goes to EXEC.
- Field rules:
  - R-type: alu_func3=ir[14:12], alu_subsra=ir[30].
  - OP-IMM: alu_subsra=ir[30] only when func3=101; otherwise 0.
  - Load, store, JALR, JAL, LUI, AUIPC, branch: alu_func3=000, alu_subsra=0.
  - mem_func3=ir[14:12] for load and store; 000 otherwise.
  - Unused rs1, rs2 and rd are driven 0.
- Operand selects:
  - op1_sel: LUI=10; AUIPC, JAL, branch=00; all others=01.
  - op2_sel: R-type=0; all others=1.
- EXEC:
  - Load/store go to MEM.
  - Branch: pc_we=1, pc_sel=branch_taken, go to FETCH.
  - All others go to WB.
- MEM: dmem_req=1, dmem_we=1 for store, held until dmem_ack.
  - Store: on ack, pc_we=1, pc_sel=0, go to FETCH.
  - Load: on ack, go to WB.
- WB: rf_we=(rd!=0), pc_we=1, pc_sel=1 for JAL/JALR else 0, go to FETCH.
- wb_sel: load=00; JAL/JALR=10; others=01.
- HALT: absorbing. Only reset leaves it. All strobes and requests are 0.

## Timing
- Reset value of every output is 0, including ir, halted and illegal. State is FETCH.
- imem_req is held 0 while reset is asserted and asserts in the first cycle after release.
- Reset mid-operation clears the state immediately and drops dmem_req in the same cycle. No rf_we or pc_we pulse follows.
- Strobes (rf_we, pc_we, imem_req, dmem_req, dmem_we) are decoded from the registered state and are single-cycle except for request holds.
- Select and index outputs are registered in DECODE. They stay stable from the cycle after DECODE until the next DECODE.
- Latency with zero-wait acks:
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- An ack arriving in a state that is not requesting is ignored.

## Structure
- Package cu_pkg holds:
  - opcode localparams;
  - the state enum (FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, 3 bits);
  - op1_sel and wb_sel encodings.
- Sub-module cu_decoder is purely combinational: ir to control bundle plus an illegal flag. It is registered in DECODE by multicycle_cu.

## Test plan
- Reset, then 0x002081B3 (add x3,x1,x2) with zero-wait acks:
  - expect rs1=1, rs2=2, rd=3, op1_sel=01, op2_sel=0, wb_sel=01;
  - rf_we and pc_we pulse together in cycle 4 after fetch start, pc_sel=0.
- 0x0080A283 (lw x5,8(x1)) with dmem_ack delayed 3 cycles:
  - dmem_req held 4 cycles, dmem_we=0, mem_func3=010, alu_func3=000;
  - rf_we pulse in WB with wb_sel=00.
- 0x0020A223 (sw x2,4(x1)): dmem_we=1, rf_we never asserts, pc_we on the ack cycle.
- 0x00208463 (beq) with branch_taken=1, then repeated with 0:
  - pc_we in EXEC with pc_sel=1, then 0;
  - total 3 cycles each.
- 0x4030D213 (srai x4,x1,3): alu_func3=101, alu_subsra=1, op2_sel=1.
- Corner cases:
  - 0x0000007F gives halted=1, illegal=1, no further imem_req.
  - 0x00000000 gives halted=1, illegal=0.
  - Asserting reset while in MEM drops dmem_req the same cycle, then the FSM refetches after release.
